// File: rtl/fifo_burst_reader.sv
// Read-side burst master for the FIFO: issues credit-limited read requests and
// presents the returned words as a valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader #(
  parameter int DW = 8,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  input  logic          ffrempty,
  output logic          ffrreq,
  input  logic [DW-1:0] ffrdata,
  input  logic          ffrvld,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [LW-1:0] xfer_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] len_q, issued;
  logic [1:0]    occ;
  logic          inflight, zdone;
  logic [DW-1:0] ent1;
  logic          pop, push, at_last, last_hs;
  logic [2:0]    credit;

  assign pop     = m_valid & m_ready;
  // Late ffrvld while idle is left over from a burst cut short by reset.
  assign push    = ffrvld & (state != IDLE);
  assign m_valid = (occ != 2'd0);
  assign at_last = (xfer_cnt == len_q - LW'(1));
  assign m_last  = m_valid & at_last;
  assign last_hs = (state == RUN) & pop & at_last;
  assign busy    = (state != IDLE);
  assign done    = (state == FIN) | zdone;

  // Words held plus the one in flight must leave room for the next return;
  // a pop this cycle frees a slot in time for it.
  assign credit  = {1'b0, occ} + {2'b00, inflight};
  assign ffrreq  = (state == RUN) & ~ffrempty & (issued < len_q)
                 & (credit < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && len != '0) state_nxt = RUN;
      RUN:     if (last_hs) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      issued   <= '0;
      xfer_cnt <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      zdone    <= 1'b0;
      m_data   <= '0;
      ent1     <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= ffrreq;
      zdone    <= (state == IDLE) & start & (len == '0);

      if (state == IDLE && start) begin
        issued   <= '0;
        xfer_cnt <= '0;
        if (len != '0) len_q <= len;
      end else begin
        if (ffrreq) issued   <= issued + LW'(1);
        if (pop)    xfer_cnt <= xfer_cnt + LW'(1);
      end

      // m_data is the head entry; ent1 is the second slot.
      if (push && (occ == 2'd0 || (occ == 2'd1 && pop)))
        m_data <= ffrdata;
      else if (pop && occ == 2'd2)
        m_data <= ent1;
      if (push && (occ == 2'd2 || (occ == 2'd1 && !pop)))
        ent1 <= ffrdata;

      if (push && !pop)      occ <= occ + 2'd1;
      else if (pop && !push) occ <= occ - 2'd1;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: behavioural FIFO model, scoreboard of
// expected words, and per-cycle checks of hold, credit and done timing.
module tb_fifo_burst_reader;
  localparam int DW = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset, start, m_ready;
  logic [LW-1:0] len;
  logic          busy, done, ffrempty, ffrreq, m_valid, m_last;
  logic          ffrvld = 1'b0;
  logic [DW-1:0] ffrdata = '0;
  logic [DW-1:0] m_data;
  logic [LW-1:0] xfer_cnt;

  fifo_burst_reader #(.DW(DW), .LW(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy), .done(done),
    .ffrempty(ffrempty), .ffrreq(ffrreq), .ffrdata(ffrdata), .ffrvld(ffrvld),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fmem [0:255];
  int wp = 0;
  int rp = 0;
  assign ffrempty = (wp == rp);
  always @(posedge clk) begin
    ffrvld <= 1'b0;
    if (ffrreq && wp != rp) begin
      ffrdata <= fmem[rp];
      ffrvld  <= 1'b1;
      rp      <= rp + 1;
    end
  end

  typedef struct packed {logic [DW-1:0] d; logic l;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int out_cnt = 0;
  logic stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic prev_last;
  logic s_ffrreq, s_mvalid, s_done, s_busy;
  int rp_snap;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    if (o !== e) begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic load(input logic [DW-1:0] d);
    fmem[wp] = d;
    wp = wp + 1;
  endtask

  task automatic push_exp(input logic [DW-1:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = base + DW'(i);
      e.l = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    logic hs;
    exp_t e;
    @(negedge clk);
    hs = m_valid & m_ready;
    s_ffrreq = ffrreq; s_mvalid = m_valid; s_done = done; s_busy = busy;
    if (stall_prev) begin
      chk("hold_valid", m_valid, 1'b1);
      chk("hold_data", m_data, prev_data);
      chk("hold_last", m_last, prev_last);
    end
    if (ffrreq) begin
      chk("credit", ((out_cnt - int'(hs)) < 2), 1'b1);
      chk("req_nonempty", ffrempty, 1'b0);
    end
    if (hs) begin
      chk("sb_nonempty", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_data", m_data, e.d);
        chk("sb_last", m_last, e.l);
      end
    end
    stall_prev = m_valid & ~m_ready;
    prev_data = m_data;
    prev_last = m_last;
    out_cnt = out_cnt + int'(ffrreq) - int'(hs);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    s_done = 1'b0;
    for (int i = 0; i < 200 && !s_done; i++) tick();
    chk(tag, s_done, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; m_ready = 1'b0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_req", ffrreq, 1'b0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, 8'h00);
    chk("rst_last", m_last, 1'b0);
    chk("rst_xfer", xfer_cnt, 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(); tick();

    for (int i = 0; i < 8; i++) load(8'h10 + 8'(i));
    push_exp(8'h10, 8);
    m_ready = 1'b1; start = 1'b1; len = 16'd8;
    tick();
    start = 1'b0; len = '0;
    tick();
    chk("lat_req_c1", s_ffrreq, 1'b1);
    chk("lat_valid_c1", s_mvalid, 1'b0);
    tick();
    chk("lat_valid_c2", s_mvalid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("basic_stream", s_mvalid, 1'b1);
      chk("basic_no_done", s_done, 1'b0);
    end
    tick();
    chk("basic_done", s_done, 1'b1);
    chk("basic_xfer", xfer_cnt, 16'd8);
    tick();
    chk("basic_done_1cyc", s_done, 1'b0);
    chk("basic_idle", s_busy, 1'b0);
    chk("basic_drain", exp_q.size(), 0);

    for (int i = 0; i < 6; i++) load(8'h20 + 8'(i));
    push_exp(8'h20, 6);
    start = 1'b1; len = 16'd6;
    tick();
    start = 1'b0;
    s_done = 1'b0;
    for (int i = 0; i < 200 && !s_done; i++) begin
      m_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    chk("bp_done", s_done, 1'b1);
    chk("bp_xfer", xfer_cnt, 16'd6);
    chk("bp_drain", exp_q.size(), 0);
    m_ready = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) load(8'h30 + 8'(i));
    push_exp(8'h30, 5);
    start = 1'b1; len = 16'd5;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("uf_busy", s_busy, 1'b1);
    chk("uf_req", s_ffrreq, 1'b0);
    chk("uf_xfer", xfer_cnt, 16'd3);
    chk("uf_pending", exp_q.size(), 2);
    load(8'h33); load(8'h34);
    wait_done("uf_done");
    chk("uf_xfer_end", xfer_cnt, 16'd5);
    chk("uf_drain", exp_q.size(), 0);
    tick();

    for (int i = 0; i < 6; i++) load(8'h40 + 8'(i));
    rp_snap = rp;
    start = 1'b1; len = 16'd0;
    tick();
    start = 1'b0;
    chk("z_req_c0", s_ffrreq, 1'b0);
    tick();
    chk("z_done", s_done, 1'b1);
    chk("z_req_c1", s_ffrreq, 1'b0);
    chk("z_busy", s_busy, 1'b0);
    chk("z_xfer", xfer_cnt, 16'd0);
    tick();
    chk("z_done_1cyc", s_done, 1'b0);
    chk("z_no_read", rp, rp_snap);

    push_exp(8'h40, 4);
    m_ready = 1'b0; start = 1'b1; len = 16'd4;
    tick();
    len = 16'd9;
    repeat (6) tick();
    chk("ign_busy", s_busy, 1'b1);
    start = 1'b0; m_ready = 1'b1;
    wait_done("ign_done");
    chk("ign_xfer", xfer_cnt, 16'd4);
    chk("ign_drain", exp_q.size(), 0);
    chk("ign_left", wp - rp, 2);
    tick();

    for (int i = 0; i < 4; i++) load(8'h50 + 8'(i));
    m_ready = 1'b0; start = 1'b1; len = 16'd6;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mr_full", out_cnt, 2);
    chk("mr_req_off", s_ffrreq, 1'b0);
    reset = 1'b1;
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_req", ffrreq, 1'b0);
    chk("mr_valid", m_valid, 1'b0);
    chk("mr_data", m_data, 8'h00);
    chk("mr_last", m_last, 1'b0);
    chk("mr_xfer", xfer_cnt, 16'd0);
    chk("mr_done", done, 1'b0);
    exp_q.delete();
    out_cnt = 0;
    stall_prev = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    push_exp(8'h50, 2);
    m_ready = 1'b1; start = 1'b1; len = 16'd2;
    tick();
    start = 1'b0;
    wait_done("mr2_done");
    chk("mr2_xfer", xfer_cnt, 16'd2);
    chk("mr2_drain", exp_q.size(), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
